mul_operand_slave: RTL

- Responder end of the operand-fetch / product-writeback handshake interface used by the multiplier master.
- Holds a small 16-bit operand memory that serves dual-address reads on the AR/R channels.
- Holds a 32-bit result memory that accepts product writes on the AW/W/B channels.
- Side ports let the system or bench preload operands and read back stored products.

---
 rtl/mul_axi_pkg.sv | 20 ++
 rtl/mul_addr_decode.sv | 26 ++
 rtl/mul_operand_slave.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_axi_pkg.sv
// Shared response codes, FSM state encodings and default address map for the
// multiplier operand/result slave.
package mul_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] DEF_OPR_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_RES_BASE = 32'h0000_1000;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE = 1'b0;
  localparam rd_state_t R_RESP = 1'b1;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE   = 2'd0;
  localparam wr_state_t W_COMMIT = 2'd1;
  localparam wr_state_t W_RESP   = 2'd2;

endpackage

// File: rtl/mul_addr_decode.sv
// Combinational byte-address decode: alignment, base/range check and word index.
module mul_addr_decode
  import mul_axi_pkg::*;
#(
  parameter logic [31:0] BASE       = DEF_OPR_BASE,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LOG2_BYTES = 1,
  localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [31:0]   i_addr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [32:0] w_off;
  logic [32:0] w_span;
  logic [31:0] w_mask;

  // Bit 32 of the widened difference is the borrow, i.e. addr < BASE.
  assign w_off   = {1'b0, i_addr} - {1'b0, BASE};
  assign w_span  = 33'(DEPTH) << LOG2_BYTES;
  assign w_mask  = (32'd1 << LOG2_BYTES) - 32'd1;
  assign o_valid = !w_off[32] && (w_off < w_span) && ((i_addr & w_mask) == '0);
  assign o_idx   = w_off[LOG2_BYTES +: IW];

endmodule

// File: rtl/mul_operand_slave.sv
// Responder for the multiplier master: dual-operand reads on AR/R from a 16-bit
// operand memory, product writes on AW/W/B into a 32-bit result memory.
module mul_operand_slave
  import mul_axi_pkg::*;
#(
  parameter int unsigned OPR_DEPTH = 16,
  parameter int unsigned RES_DEPTH = 16,
  parameter logic [31:0] OPR_BASE  = DEF_OPR_BASE,
  parameter logic [31:0] RES_BASE  = DEF_RES_BASE,
  localparam int unsigned OIW      = (OPR_DEPTH > 1) ? $clog2(OPR_DEPTH) : 1,
  localparam int unsigned RIW      = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  input  logic           M_arvalid,
  input  logic [31:0]    M_Raddr1,
  input  logic [31:0]    M_Raddr2,
  output logic           S_arready,
  output logic           S_rvalid,
  input  logic           M_rready,
  output logic [15:0]    S_Rdata1,
  output logic [15:0]    S_Rdata2,
  output logic [1:0]     S_rresp,
  input  logic           M_awvalid,
  input  logic [31:0]    M_Waddr,
  output logic           S_awready,
  input  logic           M_wvalid,
  input  logic [31:0]    M_Wdata,
  output logic           S_wready,
  output logic           S_bvalid,
  input  logic           M_bready,
  output logic [1:0]     S_bresp,
  input  logic           load_en,
  input  logic [OIW-1:0] load_idx,
  input  logic [15:0]    load_data,
  input  logic [RIW-1:0] res_idx,
  output logic [31:0]    res_data
);

  logic [15:0] r_opr [OPR_DEPTH];
  logic [31:0] r_res [RES_DEPTH];

  rd_state_t   r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic [15:0] r_rdata1;
  logic [15:0] r_rdata2;
  logic [1:0]  r_rresp;

  wr_state_t   r_wstate;
  logic        r_aw_got;
  logic        r_w_got;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [31:0] r_res_data;

  logic           w_v1;
  logic           w_v2;
  logic           w_vr;
  logic [OIW-1:0] w_i1;
  logic [OIW-1:0] w_i2;
  logic [RIW-1:0] w_ir;
  logic           w_ar_hs;
  logic           w_aw_hs;
  logic           w_w_hs;
  logic           w_aw_next;
  logic           w_w_next;
  logic           w_commit;

  mul_addr_decode #(.BASE(OPR_BASE), .DEPTH(OPR_DEPTH), .LOG2_BYTES(1)) u_dec_op1 (
    .i_addr (M_Raddr1),
    .o_valid(w_v1),
    .o_idx  (w_i1)
  );

  mul_addr_decode #(.BASE(OPR_BASE), .DEPTH(OPR_DEPTH), .LOG2_BYTES(1)) u_dec_op2 (
    .i_addr (M_Raddr2),
    .o_valid(w_v2),
    .o_idx  (w_i2)
  );

  mul_addr_decode #(.BASE(RES_BASE), .DEPTH(RES_DEPTH), .LOG2_BYTES(2)) u_dec_res (
    .i_addr (r_waddr),
    .o_valid(w_vr),
    .o_idx  (w_ir)
  );

  assign w_ar_hs   = M_arvalid & r_arready;
  assign w_aw_hs   = M_awvalid & r_awready;
  assign w_w_hs    = M_wvalid & r_wready;
  assign w_aw_next = r_aw_got | w_aw_hs;
  assign w_w_next  = r_w_got | w_w_hs;
  assign w_commit  = (r_wstate == W_COMMIT) && w_vr;

  // Preload writes land via NBA, so a same-edge AR to that word sees the old value.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < OPR_DEPTH; i++) r_opr[i] <= '0;
    end else if (load_en) begin
      r_opr[load_idx] <= load_data;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < RES_DEPTH; i++) r_res[i] <= '0;
      r_res_data <= '0;
    end else begin
      if (w_commit) r_res[w_ir] <= r_wdata;
      r_res_data <= r_res[res_idx];
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      r_arready <= 1'b1;
      if (w_ar_hs) begin
        r_rdata1  <= w_v1 ? r_opr[w_i1] : '0;
        r_rdata2  <= w_v2 ? r_opr[w_i2] : '0;
        r_rresp   <= (w_v1 && w_v2) ? RESP_OKAY : RESP_SLVERR;
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
        r_rstate  <= R_RESP;
      end
    end else if (M_rready) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
      r_rstate  <= R_IDLE;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_wstate  <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) r_waddr <= M_Waddr;
          if (w_w_hs)  r_wdata <= M_Wdata;
          r_aw_got <= w_aw_next;
          r_w_got  <= w_w_next;
          if (w_aw_next && w_w_next) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_COMMIT;
          end else begin
            r_awready <= !w_aw_next;
            r_wready  <= !w_w_next;
          end
        end
        W_COMMIT: begin
          r_bvalid <= 1'b1;
          r_bresp  <= w_vr ? RESP_OKAY : RESP_SLVERR;
          r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (M_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign S_arready = r_arready;
  assign S_rvalid  = r_rvalid;
  assign S_Rdata1  = r_rdata1;
  assign S_Rdata2  = r_rdata2;
  assign S_rresp   = r_rresp;
  assign S_awready = r_awready;
  assign S_wready  = r_wready;
  assign S_bvalid  = r_bvalid;
  assign S_bresp   = r_bresp;
  assign res_data  = r_res_data;

endmodule
